branch_resolve_stage: RTL and testbench
=======================================

// Module: branch_resolve_stage
// PURPOSE
//  Sits directly downstream of the 32-bit magnitude comparator in the EX stage.
//  Registers the comparator flags and decodes the branch type into a taken/not-taken decision.
//  Computes the branch target and issues a one-cycle fetch redirect after the result is accepted.
//  Uses a valid/ready handshake on both sides and accepts a kill from later stages.
// PARAMETERS
//  XLEN    32  datapath / PC width
//  CNT_W   16  width of statistics counters (only when BRANCH_STATS_EN is defined)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       upstream has a branch to resolve
//  in_ready     out  1       stage can accept this cycle
//  br_type      in   3       0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 B (always), 7 reserved
//  cmp_bigger   in   1       comparator bigger flag (rs vs rt, or rs vs 0 for 2..5)
//  cmp_equal    in   1       comparator equal flag
//  cmp_less     in   1       comparator less flag
//  rs_sign      in   1       rs[XLEN-1]; supplies the sign for compares against zero
//  pc_plus4     in   XLEN    PC of the branch + 4
//  imm16        in   16      branch offset in instruction words
//  out_valid    out  1       resolved result held for downstream
//  out_ready    in   1       downstream accepts the result
//  out_taken    out  1       branch taken
//  out_target   out  XLEN    taken target, or pc_plus4 when not taken
//  redirect     out  1       one-cycle fetch redirect pulse
//  redirect_pc  out  XLEN    fetch address; valid only while redirect=1
//  kill         in   1       synchronous squash from a later stage
// BEHAVIOUR
//  - Reset: state IDLE, and out_valid, out_taken, redirect = 0.
//    out_target and redirect_pc reset to 0.
//  - Taken decode (uses the registered flags):
//      BEQ = equal;  BNE = !equal;  BLEZ = rs_sign | equal;  BGTZ = !rs_sign & bigger;
//      BLTZ = rs_sign;  BGEZ = !rs_sign;  B = 1;  type 7 = 0.
//    cmp_less is registered for debug only.
//  - Target = pc_plus4 + (sext(imm16) << 2), modulo 2^XLEN. Wrap-around is silent; there is no fault.
//  - in_ready = (state==IDLE) | (state==RESOLVED & out_ready & !out_taken).
//    in_ready is 0 in REDIRECT.
//  - Latency: a result is accepted at edge N; out_valid=1 from cycle N+1.
//    For a taken branch, redirect pulses in the cycle after the out handshake.
//  - FSM:
//      IDLE:     on in_valid&in_ready, capture the inputs -> RESOLVED.
//      RESOLVED: out_valid=1 and all out_* held stable until out_ready.
//                On out_ready & taken -> REDIRECT.
//                On out_ready & !taken -> RESOLVED if a new input is accepted in the same cycle, else IDLE.
//      REDIRECT: redirect=1 and redirect_pc=target for exactly 1 cycle, out_valid=0 -> IDLE.
//  - kill has priority over every event in the same cycle: state -> IDLE next cycle.
//    A kill drops the held result and any same-cycle capture, and suppresses a pending redirect.
//    If kill is asserted in REDIRECT, the pulse already on the wire that cycle still completes.
//  - Reset asserted mid-operation aborts immediately.
//    redirect deasserts asynchronously and no partial result is emitted.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//   - Adds output ports stat_taken [CNT_W] and stat_not_taken [CNT_W].
//   - A counter increments on each out handshake, by outcome. Killed results are not counted.
//   - Counters saturate at all-ones and reset to 0.
//  BRANCH_STATS_EN not defined:
//   - No counters and no extra ports. Behaviour is otherwise identical.
// TESTING
//  1. BEQ with equal=1, pc_plus4=0x00400010, imm16=0x0004, out_ready=1:
//     out_taken=1, out_target=0x00400020; redirect=1 one cycle later with redirect_pc=0x00400020.
//  2. BNE with equal=1:
//     out_taken=0, out_target=pc_plus4; redirect never asserts.
//     A back-to-back input is accepted in the handshake cycle.
//  3. BGTZ with rs_sign=1, bigger=1: not taken. BLEZ with rs_sign=0, equal=1: taken.
//     Sweep all 8 br_type values against the decode table.
//  4. Backpressure: out_ready=0 for 5 cycles.
//     Outputs stay stable, in_ready=0, redirect=0; all release on the first cycle out_ready=1.
//  5. imm16=0x8000, pc_plus4=0x00000004:
//     target=0xFFFE0004 (negative offset wraps with no error).
//  6. kill in RESOLVED with a taken result: no redirect, out_valid=0 next cycle, and stats unchanged when enabled.
//     Asserting rst_n=0 mid-REDIRECT clears everything immediately.

Source files
------------

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: registers comparator flags, decodes taken/not-taken, computes target
// and issues a one-cycle fetch redirect. Optional statistics counters under `BRANCH_STATS_EN`.
module branch_resolve_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      br_type,
    input  logic            cmp_bigger,
    input  logic            cmp_equal,
    input  logic            cmp_less,
    input  logic            rs_sign,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [15:0]     imm16,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_not_taken,
`endif
    output logic [1:0]      dbg_state,
    output logic            dbg_cmp_less,
    input  logic            kill
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
    // rising edge; out_* stay stable while out_valid=1 and out_ready=0.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RESOLVED = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      type_q;
    logic            eq_q, big_q, less_q, sign_q;
    logic [XLEN-1:0] pc4_q, target_q;
    logic [XLEN-1:0] target_calc;
    logic            capture;
    logic            taken_dec;
    logic            out_hs;

    assign target_calc = pc_plus4 + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        taken_dec = 1'b0;
        case (type_q)
            3'd0:    taken_dec = eq_q;
            3'd1:    taken_dec = !eq_q;
            3'd2:    taken_dec = sign_q | eq_q;
            3'd3:    taken_dec = !sign_q & big_q;
            3'd4:    taken_dec = sign_q;
            3'd5:    taken_dec = !sign_q;
            3'd6:    taken_dec = 1'b1;
            default: taken_dec = 1'b0;
        endcase
    end

    assign out_valid   = (state_q == S_RESOLVED);
    assign out_taken   = out_valid & taken_dec;
    assign out_target  = taken_dec ? target_q : pc4_q;
    assign redirect    = (state_q == S_REDIRECT);
    assign redirect_pc = redirect ? target_q : '0;
    assign in_ready    = (state_q == S_IDLE) |
                         ((state_q == S_RESOLVED) & out_ready & !taken_dec);
    assign out_hs      = out_valid & out_ready;
    assign dbg_state   = state_q;
    assign dbg_cmp_less = less_q;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = S_RESOLVED;
                end
            end
            S_RESOLVED: begin
                if (out_ready) begin
                    if (taken_dec) begin
                        state_d = S_REDIRECT;
                    end else if (in_valid) begin
                        capture = 1'b1;
                        state_d = S_RESOLVED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Kill wins over everything: drops held result, same-cycle capture and pending redirect.
        if (kill) begin
            state_d = S_IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            type_q   <= 3'd0;
            eq_q     <= 1'b0;
            big_q    <= 1'b0;
            less_q   <= 1'b0;
            sign_q   <= 1'b0;
            pc4_q    <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                type_q   <= br_type;
                eq_q     <= cmp_equal;
                big_q    <= cmp_bigger;
                less_q   <= cmp_less;
                sign_q   <= rs_sign;
                pc4_q    <= pc_plus4;
                target_q <= target_calc;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_taken_q, stat_not_taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
        end else if (out_hs && !kill) begin
            if (taken_dec) begin
                if (stat_taken_q != '1) stat_taken_q <= stat_taken_q + 1'b1;
            end else begin
                if (stat_not_taken_q != '1) stat_not_taken_q <= stat_not_taken_q + 1'b1;
            end
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed self-checking bench for branch_resolve_stage.
module tb_branch_resolve_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  br_type;
    logic        cmp_bigger, cmp_equal, cmp_less, rs_sign;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic        out_valid, out_ready, out_taken;
    logic [31:0] out_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;
    logic        dbg_cmp_less;
    logic        kill;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken, stat_not_taken;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .br_type(br_type), .cmp_bigger(cmp_bigger), .cmp_equal(cmp_equal),
        .cmp_less(cmp_less), .rs_sign(rs_sign),
        .pc_plus4(pc_plus4), .imm16(imm16),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef BRANCH_STATS_EN
        .stat_taken(stat_taken), .stat_not_taken(stat_not_taken),
`endif
        .dbg_state(dbg_state), .dbg_cmp_less(dbg_cmp_less),
        .kill(kill)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic eq, input logic big, input logic sg,
                         input logic [31:0] pc4, input logic [15:0] imm);
        in_valid   = 1'b1;
        br_type    = t;
        cmp_equal  = eq;
        cmp_bigger = big;
        cmp_less   = !eq & !big;
        rs_sign    = sg;
        pc_plus4   = pc4;
        imm16      = imm;
    endtask

    task automatic idle_in;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; kill = 1'b0;
        br_type = 3'd0; cmp_bigger = 1'b0; cmp_equal = 1'b0; cmp_less = 1'b0;
        rs_sign = 1'b0; pc_plus4 = '0; imm16 = '0;
        repeat (3) step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        n_vec++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL reset_out_taken got %0h exp 0", out_taken); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect got %0h exp 0", redirect); end
        n_vec++; if (out_target !== 32'h0) begin n_err++; $display("FAIL reset_out_target got %h exp 0", out_target); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        rst_n = 1'b1;
        step();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    endtask

    task automatic test_beq_taken;
        out_ready = 1'b1;
        drive(3'd0, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 16'h0004);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL beq_in_ready got %0h exp 1", in_ready); end
        step();
        idle_in();
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_out_valid got %0h exp 1", out_valid); end
        n_vec++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL beq_out_taken got %0h exp 1", out_taken); end
        n_vec++; if (out_target !== 32'h0040_0020) begin n_err++; $display("FAIL beq_out_target got %h exp 00400020", out_target); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL beq_in_ready_taken got %0h exp 0", in_ready); end
        step();
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL beq_redirect got %0h exp 1", redirect); end
        n_vec++; if (redirect_pc !== 32'h0040_0020) begin n_err++; $display("FAIL beq_redirect_pc got %h exp 00400020", redirect_pc); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL beq_redir_out_valid got %0h exp 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL beq_redir_in_ready got %0h exp 0", in_ready); end
        step();
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL beq_redirect_one_cycle got %0h exp 0", redirect); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL beq_back_idle got %0h exp 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'h0010);
        step();
        idle_in();
        #1;
        n_vec++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL bne_out_taken got %0h exp 0", out_taken); end
        n_vec++; if (out_target !== 32'h0000_0100) begin n_err++; $display("FAIL bne_out_target got %h exp 00000100", out_target); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL bne_redirect got %0h exp 0", redirect); end
        out_ready = 1'b1;
        drive(3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 16'h0002);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %0h exp 1", in_ready); end
        step();
        idle_in();
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid got %0h exp 1", out_valid); end
        n_vec++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL b2b_out_taken got %0h exp 1", out_taken); end
        n_vec++; if (out_target !== 32'h0000_0208) begin n_err++; $display("FAIL b2b_out_target got %h exp 00000208", out_target); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL b2b_no_redirect got %0h exp 0", redirect); end
        step();
        n_vec++; if (redirect_pc !== 32'h0000_0208) begin n_err++; $display("FAIL b2b_redirect_pc got %h exp 00000208", redirect_pc); end
        step();
    endtask

    // type, equal, bigger, rs_sign, expected taken
    task automatic test_decode_sweep;
        logic [2:0] tv_type [15] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3,
                                     3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        logic tv_eq   [15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic tv_big  [15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic tv_sign [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic tv_exp  [15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_tgt;
        for (int i = 0; i < 15; i++) begin
            out_ready = 1'b0;
            drive(tv_type[i], tv_eq[i], tv_big[i], tv_sign[i], 32'h0000_1000, 16'hFFFF);
            step();
            idle_in();
            exp_tgt = tv_exp[i] ? 32'h0000_0FFC : 32'h0000_1000;
            n_vec++; if (out_taken !== tv_exp[i]) begin n_err++; $display("FAIL sweep%0d_taken got %0h exp %0h", i, out_taken, tv_exp[i]); end
            n_vec++; if (out_target !== exp_tgt) begin n_err++; $display("FAIL sweep%0d_target got %h exp %h", i, out_target, exp_tgt); end
            out_ready = 1'b1;
            step();
            n_vec++; if (redirect !== tv_exp[i]) begin n_err++; $display("FAIL sweep%0d_redirect got %0h exp %0h", i, redirect, tv_exp[i]); end
            if (tv_exp[i]) step();
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(3'd0, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 16'h0004);
        step();
        idle_in();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_out_valid got %0h exp 1", c, out_valid); end
            n_vec++; if (out_target !== 32'h0040_0020) begin n_err++; $display("FAIL bp%0d_target got %h exp 00400020", c, out_target); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d_in_ready got %0h exp 0", c, in_ready); end
            n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL bp%0d_redirect got %0h exp 0", c, redirect); end
            step();
        end
        out_ready = 1'b1;
        step();
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL bp_release_redirect got %0h exp 1", redirect); end
        step();
    endtask

    task automatic test_wrap;
        out_ready = 1'b0;
        drive(3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 16'h8000);
        step();
        idle_in();
        n_vec++; if (out_target !== 32'hFFFE_0004) begin n_err++; $display("FAIL wrap_target got %h exp fffe0004", out_target); end
        out_ready = 1'b1;
        step();
        n_vec++; if (redirect_pc !== 32'hFFFE_0004) begin n_err++; $display("FAIL wrap_redirect_pc got %h exp fffe0004", redirect_pc); end
        step();
    endtask

    task automatic test_kill;
`ifdef BRANCH_STATS_EN
        logic [15:0] st_t0;
        st_t0 = stat_taken;
`endif
        // kill in RESOLVED with a taken result
        out_ready = 1'b0;
        drive(3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 16'h0001);
        step();
        idle_in();
        kill = 1'b1; out_ready = 1'b1;
        step();
        kill = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_out_valid got %0h exp 0", out_valid); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL kill_redirect got %0h exp 0", redirect); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL kill_state got %0d exp 0", dbg_state); end
        step();
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL kill_redirect_late got %0h exp 0", redirect); end
`ifdef BRANCH_STATS_EN
        n_vec++; if (stat_taken !== st_t0) begin n_err++; $display("FAIL kill_stats got %0d exp %0d", stat_taken, st_t0); end
`endif
        // kill with a same-cycle capture in IDLE
        drive(3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 16'h0001);
        kill = 1'b1;
        step();
        kill = 1'b0; idle_in();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_capture got %0h exp 0", out_valid); end
        // kill during REDIRECT: the pulse still completes
        drive(3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 16'h0001);
        step();
        idle_in();
        step();
        kill = 1'b1;
        #1;
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL kill_in_redirect_pulse got %0h exp 1", redirect); end
        n_vec++; if (redirect_pc !== 32'h0000_3004) begin n_err++; $display("FAIL kill_in_redirect_pc got %h exp 00003004", redirect_pc); end
        step();
        kill = 1'b0;
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL kill_in_redirect_end got %0h exp 0", redirect); end
`ifdef BRANCH_STATS_EN
        n_vec++; if (stat_taken !== st_t0 + 16'd1) begin n_err++; $display("FAIL stats_taken got %0d exp %0d", stat_taken, st_t0 + 16'd1); end
`endif
    endtask

    task automatic test_reset_mid_redirect;
        out_ready = 1'b1;
        drive(3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 16'h0010);
        step();
        idle_in();
        step();
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL rst_pre_redirect got %0h exp 1", redirect); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect got %0h exp 0", redirect); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_redirect_pc got %h exp 0", redirect_pc); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
        n_vec++; if (out_target !== 32'h0) begin n_err++; $display("FAIL rst_out_target got %h exp 0", out_target); end
`ifdef BRANCH_STATS_EN
        n_vec++; if (stat_taken !== 16'd0) begin n_err++; $display("FAIL rst_stats got %0d exp 0", stat_taken); end
`endif
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_back_to_back();
        test_decode_sweep();
        test_backpressure();
        test_wrap();
        test_kill();
        test_reset_mid_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
